// File: rtl/reorder_pingpong_sched.sv
// Ping-pong address scheduler for the two-bank FFT output re-order memory.
// The write side fills banks in natural order; the read side drains completed
// banks with digit-reversed addresses. The banks alternate so one frame can
// fill while the previous one drains.
// Optional build macro: REORDER_SCHED_BYPASS_EN adds cfg_bypass. The value is
// latched per bank at the first write of a frame and selects natural-order
// reads for that frame.
// ADDR_WIDTH must be a multiple of DIGIT_WIDTH, and RD_LAT must be at least 1.
module reorder_pingpong_sched #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DIGIT_WIDTH = 4,
    parameter int RD_LAT      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef REORDER_SCHED_BYPASS_EN
    input  logic                  cfg_bypass,
`endif
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic                  wr_en,
    output logic                  wr_bank,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic                  rd_ready,
    output logic                  rd_en,
    output logic                  rd_bank,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  out_valid,
    output logic                  out_last,
    output logic                  err_ovf
);

    localparam int NUM_DIGITS = ADDR_WIDTH / DIGIT_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_FILLING  = 2'd1,
        ST_FULL     = 2'd2,
        ST_DRAINING = 2'd3
    } bank_state_t;

    bank_state_t           state_reg [2];
    bank_state_t           state_next [2];
    logic                  wr_sel_reg, wr_sel_next;
    logic                  rd_sel_reg, rd_sel_next;
    logic [ADDR_WIDTH-1:0] wr_cnt_reg, wr_cnt_next;
    logic [ADDR_WIDTH-1:0] rd_cnt_reg, rd_cnt_next;
    logic                  err_ovf_reg, err_ovf_next;
    logic [RD_LAT-1:0]     valid_pipe_reg;
    logic [RD_LAT-1:0]     last_pipe_reg;

    logic                  wr_last;
    logic                  rd_last;
    logic                  rd_avail;
    logic [ADDR_WIDTH-1:0] rd_addr_rev;

    // Write acceptance depends on registered bank state only, so there is no
    // combinational path from the read side into wr_ready.
    assign wr_ready = (state_reg[wr_sel_reg] == ST_EMPTY) ||
                      (state_reg[wr_sel_reg] == ST_FILLING);
    assign wr_en    = wr_valid & wr_ready;
    assign wr_bank  = wr_sel_reg;
    assign wr_addr  = wr_cnt_reg;
    assign wr_last  = (wr_cnt_reg == CNT_MAX);

    assign rd_avail = (state_reg[rd_sel_reg] == ST_FULL) ||
                      (state_reg[rd_sel_reg] == ST_DRAINING);
    assign rd_en    = rd_ready & rd_avail;
    assign rd_bank  = rd_sel_reg;
    assign rd_last  = (rd_cnt_reg == CNT_MAX);

    assign out_valid = valid_pipe_reg[RD_LAT-1];
    assign out_last  = last_pipe_reg[RD_LAT-1];
    assign err_ovf   = err_ovf_reg;

    // The least-significant digit of the read count becomes the most-significant
    // digit of the address, and so on down.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_rev
        assign rd_addr_rev[gi*DIGIT_WIDTH +: DIGIT_WIDTH] =
            rd_cnt_reg[(NUM_DIGITS-1-gi)*DIGIT_WIDTH +: DIGIT_WIDTH];
    end

`ifdef REORDER_SCHED_BYPASS_EN
    logic bypass_reg [2];
    logic bypass_next [2];

    assign rd_addr = bypass_reg[rd_sel_reg] ? rd_cnt_reg : rd_addr_rev;

    // Latch cfg_bypass when a bank takes the first write of a new frame.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bypass_next[b] = bypass_reg[b];
            if (wr_en && (wr_sel_reg == 1'(b)) && (state_reg[b] == ST_EMPTY)) begin
                bypass_next[b] = cfg_bypass;
            end
        end
    end

    // Per-bank bypass flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) bypass_reg[b] <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) bypass_reg[b] <= bypass_next[b];
        end
    end
`else
    assign rd_addr = rd_addr_rev;
`endif

    // Bank state transitions, counters and bank selects. A bank is never
    // simultaneously written and read, so the two updates cannot collide.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            state_next[b] = state_reg[b];
            if (wr_en && (wr_sel_reg == 1'(b))) begin
                if (wr_last) begin
                    state_next[b] = ST_FULL;
                end else if (state_reg[b] == ST_EMPTY) begin
                    state_next[b] = ST_FILLING;
                end
            end
            if (rd_en && (rd_sel_reg == 1'(b))) begin
                if (rd_last) begin
                    state_next[b] = ST_EMPTY;
                end else begin
                    state_next[b] = ST_DRAINING;
                end
            end
        end
        wr_cnt_next  = wr_en ? wr_cnt_reg + ADDR_WIDTH'(1) : wr_cnt_reg;
        rd_cnt_next  = rd_en ? rd_cnt_reg + ADDR_WIDTH'(1) : rd_cnt_reg;
        wr_sel_next  = wr_sel_reg ^ (wr_en & wr_last);
        rd_sel_next  = rd_sel_reg ^ (rd_en & rd_last);
        err_ovf_next = err_ovf_reg | (wr_valid & ~wr_ready);
    end

    // State register for both banks and the shared counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) state_reg[b] <= ST_EMPTY;
            wr_sel_reg  <= 1'b0;
            rd_sel_reg  <= 1'b0;
            wr_cnt_reg  <= '0;
            rd_cnt_reg  <= '0;
            err_ovf_reg <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) state_reg[b] <= state_next[b];
            wr_sel_reg  <= wr_sel_next;
            rd_sel_reg  <= rd_sel_next;
            wr_cnt_reg  <= wr_cnt_next;
            rd_cnt_reg  <= rd_cnt_next;
            err_ovf_reg <= err_ovf_next;
        end
    end

    // Delay rd_en and the end-of-frame marker by the memory read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_pipe_reg <= '0;
            last_pipe_reg  <= '0;
        end else begin
            valid_pipe_reg[0] <= rd_en;
            last_pipe_reg[0]  <= rd_en & rd_last;
            for (int i = 1; i < RD_LAT; i++) begin
                valid_pipe_reg[i] <= valid_pipe_reg[i-1];
                last_pipe_reg[i]  <= last_pipe_reg[i-1];
            end
        end
    end

endmodule

// File: tb/tb_reorder_pingpong_sched.sv
// Testbench for reorder_pingpong_sched with default parameters.
// Directed vectors with a running scoreboard. Define REORDER_SCHED_BYPASS_EN
// to include the bypass scenario.
module tb_reorder_pingpong_sched;

    localparam int FRAME = 4096;
    localparam int LOG   = 8192;

    typedef struct {
        int          idx;
        logic [11:0] exp_addr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic        rd_ready = 1'b0;
    logic        wr_ready, wr_en, wr_bank, rd_en, rd_bank;
    logic        out_valid, out_last, err_ovf;
    logic [11:0] wr_addr, rd_addr;
`ifdef REORDER_SCHED_BYPASS_EN
    logic        cfg_bypass = 1'b0;
`endif

    reorder_pingpong_sched #(.ADDR_WIDTH(12), .DIGIT_WIDTH(4), .RD_LAT(1)) dut (
        .clk(clk),
        .rst(rst),
`ifdef REORDER_SCHED_BYPASS_EN
        .cfg_bypass(cfg_bypass),
`endif
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_en(wr_en),
        .wr_bank(wr_bank),
        .wr_addr(wr_addr),
        .rd_ready(rd_ready),
        .rd_en(rd_en),
        .rd_bank(rd_bank),
        .rd_addr(rd_addr),
        .out_valid(out_valid),
        .out_last(out_last),
        .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // sampled outputs of the latest step
    logic        s_wr_ready, s_wr_en, s_wr_bank, s_rd_en, s_rd_bank;
    logic        s_out_valid, s_out_last, s_err_ovf;
    logic [11:0] s_wr_addr, s_rd_addr;

    // scoreboard state
    int   cyc = 0;
    int   wr_idx = 0, wr_frame = 0, rd_idx = 0, rd_frame = 0;
    logic prev_rd_en = 1'b0, prev_last = 1'b0;
    logic bp_frame [2] = '{1'b0, 1'b0};
    int   sb_err_wr = 0, sb_err_rd = 0, sb_err_ov = 0;
    int   n_wr, n_rd, n_notready, n_outlast, n_outvalid, first_rd_cyc, last_wr_cyc;
    logic [11:0] rd_log [LOG];

    function automatic logic [11:0] rev3(input int i);
        logic [11:0] v;
        v = 12'(i);
        return {v[3:0], v[7:4], v[11:8]};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic clr();
        n_wr = 0; n_rd = 0; n_notready = 0; n_outlast = 0; n_outvalid = 0;
        first_rd_cyc = -1; last_wr_cyc = -1;
    endtask

    task automatic sb_check(input string tag);
        chk({tag, " sb_write"}, sb_err_wr, 0);
        chk({tag, " sb_read"}, sb_err_rd, 0);
        chk({tag, " sb_outvalid"}, sb_err_ov, 0);
        sb_err_wr = 0; sb_err_rd = 0; sb_err_ov = 0;
    endtask

    // One clock cycle: drive inputs, sample at the falling edge, update the scoreboard.
    task automatic step(input logic wv, input logic rr, input logic rs);
        logic        was_last;
        logic [11:0] exp_a;
        wr_valid = wv; rd_ready = rr; rst = rs;
        @(negedge clk);
        s_wr_ready = wr_ready; s_wr_en = wr_en; s_wr_bank = wr_bank; s_wr_addr = wr_addr;
        s_rd_en = rd_en; s_rd_bank = rd_bank; s_rd_addr = rd_addr;
        s_out_valid = out_valid; s_out_last = out_last; s_err_ovf = err_ovf;
        if (!rs) begin
            if (s_wr_en !== (wv & s_wr_ready)) sb_err_wr++;
            if (s_out_valid !== prev_rd_en) sb_err_ov++;
            if (s_out_last !== prev_last) sb_err_ov++;
            if (s_out_valid === 1'b1) n_outvalid++;
            if (s_out_last === 1'b1) n_outlast++;
            if (s_wr_ready !== 1'b1) n_notready++;
            if (s_wr_en === 1'b1) begin
`ifdef REORDER_SCHED_BYPASS_EN
                if (wr_idx == 0) bp_frame[wr_frame % 2] = cfg_bypass;
`endif
                if (s_wr_addr !== 12'(wr_idx) || s_wr_bank !== (wr_frame % 2 == 1)) sb_err_wr++;
                n_wr++;
                last_wr_cyc = cyc;
                wr_idx++;
                if (wr_idx == FRAME) begin wr_idx = 0; wr_frame++; end
            end
            was_last = 1'b0;
            if (s_rd_en === 1'b1) begin
                exp_a = bp_frame[rd_frame % 2] ? 12'(rd_idx) : rev3(rd_idx);
                if (s_rd_addr !== exp_a || s_rd_bank !== (rd_frame % 2 == 1)) sb_err_rd++;
                if (n_rd < LOG) rd_log[n_rd] = s_rd_addr;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                n_rd++;
                was_last = (rd_idx == FRAME - 1);
                rd_idx++;
                if (rd_idx == FRAME) begin rd_idx = 0; rd_frame++; end
            end
            prev_rd_en = (s_rd_en === 1'b1);
            prev_last  = was_last;
        end else begin
            wr_idx = 0; wr_frame = 0; rd_idx = 0; rd_frame = 0;
            prev_rd_en = 1'b0; prev_last = 1'b0;
            bp_frame[0] = 1'b0; bp_frame[1] = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // watchdog so the run always ends
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    vec_t tbl [12];

    initial begin
        int mism;
        tbl[0]  = '{idx: 'h000, exp_addr: 12'h000};
        tbl[1]  = '{idx: 'h001, exp_addr: 12'h100};
        tbl[2]  = '{idx: 'h002, exp_addr: 12'h200};
        tbl[3]  = '{idx: 'h00F, exp_addr: 12'hF00};
        tbl[4]  = '{idx: 'h010, exp_addr: 12'h010};
        tbl[5]  = '{idx: 'h011, exp_addr: 12'h110};
        tbl[6]  = '{idx: 'h123, exp_addr: 12'h321};
        tbl[7]  = '{idx: 'h0AB, exp_addr: 12'hBA0};
        tbl[8]  = '{idx: 'h800, exp_addr: 12'h008};
        tbl[9]  = '{idx: 'hFFF, exp_addr: 12'hFFF};
        tbl[10] = '{idx: 'h456, exp_addr: 12'h654};
        tbl[11] = '{idx: 'h0F0, exp_addr: 12'h0F0};

        // ---- scenario 1: reset state, one frame, digit-reversed drain
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        chk("reset wr_ready", 32'(s_wr_ready), 1);
        chk("reset wr_en", 32'(s_wr_en), 0);
        chk("reset wr_addr", 32'(s_wr_addr), 0);
        chk("reset wr_bank", 32'(s_wr_bank), 0);
        chk("reset rd_en", 32'(s_rd_en), 0);
        chk("reset rd_bank", 32'(s_rd_bank), 0);
        chk("reset out_valid", 32'(s_out_valid), 0);
        chk("reset out_last", 32'(s_out_last), 0);
        chk("reset err_ovf", 32'(s_err_ovf), 0);
        clr();
        for (int i = 0; i < FRAME; i++) step(1'b1, 1'b1, 1'b0);
        chk("s1 writes", n_wr, FRAME);
        chk("s1 reads during fill", n_rd, 0);
        for (int i = 0; i < FRAME + 3; i++) step(1'b0, 1'b1, 1'b0);
        chk("s1 first read latency", first_rd_cyc - last_wr_cyc, 1);
        chk("s1 reads", n_rd, FRAME);
        chk("s1 out_valid count", n_outvalid, FRAME);
        chk("s1 out_last count", n_outlast, 1);
        for (int v = 0; v < 12; v++) begin
            chk($sformatf("s1 rd_addr[0x%0h]", tbl[v].idx), 32'(rd_log[tbl[v].idx]), 32'(tbl[v].exp_addr));
        end
        sb_check("s1");
        $display("scenario 1: one frame written and drained, reads=%0d", n_rd);

        // ---- scenario 2: three back-to-back frames
        step(1'b0, 1'b0, 1'b1);
        clr();
        for (int i = 0; i < 3 * FRAME; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (i == FRAME) begin
                chk("s2 overlap rd_en", 32'(s_rd_en), 1);
                chk("s2 overlap wr_bank", 32'(s_wr_bank), 1);
                chk("s2 overlap rd_bank", 32'(s_rd_bank), 0);
            end
            if (i == 2 * FRAME) begin
                chk("s2 frame2 wr_bank", 32'(s_wr_bank), 0);
                chk("s2 frame2 rd_bank", 32'(s_rd_bank), 1);
            end
        end
        for (int i = 0; i < FRAME + 3; i++) step(1'b0, 1'b1, 1'b0);
        chk("s2 wr_ready drops", n_notready, 0);
        chk("s2 writes", n_wr, 3 * FRAME);
        chk("s2 reads", n_rd, 3 * FRAME);
        chk("s2 out_last count", n_outlast, 3);
        chk("s2 err_ovf", 32'(s_err_ovf), 0);
        sb_check("s2");
        $display("scenario 2: three streamed frames, writes=%0d reads=%0d", n_wr, n_rd);

        // ---- scenario 3: both banks fill with reads stalled -> overflow
        step(1'b0, 1'b0, 1'b1);
        clr();
        for (int i = 0; i < 2 * FRAME; i++) step(1'b1, 1'b0, 1'b0);
        chk("s3 writes", n_wr, 2 * FRAME);
        chk("s3 wr_ready while filling", n_notready, 0);
        step(1'b1, 1'b0, 1'b0);
        chk("s3 full wr_ready", 32'(s_wr_ready), 0);
        chk("s3 full wr_en", 32'(s_wr_en), 0);
        chk("s3 err_ovf same cycle", 32'(s_err_ovf), 0);
        step(1'b1, 1'b0, 1'b0);
        chk("s3 err_ovf next cycle", 32'(s_err_ovf), 1);
        step(1'b1, 1'b0, 1'b0);
        clr();
        step(1'b0, 1'b1, 1'b0);
        chk("s3 first rd_en", 32'(s_rd_en), 1);
        chk("s3 first rd_bank", 32'(s_rd_bank), 0);
        chk("s3 first rd_addr", 32'(s_rd_addr), 0);
        chk("s3 wr_ready while full", 32'(s_wr_ready), 0);
        for (int g = 0; g < 5000 && n_rd < FRAME; g++) step(1'b0, 1'b1, 1'b0);
        chk("s3 bank0 reads", n_rd, FRAME);
        step(1'b0, 1'b0, 1'b0);
        chk("s3 bank0 writable", 32'(s_wr_ready), 1);
        chk("s3 wr_bank after drain", 32'(s_wr_bank), 0);
        chk("s3 rd_bank after drain", 32'(s_rd_bank), 1);
        chk("s3 stalled rd_en", 32'(s_rd_en), 0);
        chk("s3 trailing out_last", 32'(s_out_last), 1);
        sb_check("s3");
        $display("scenario 3: overflow flagged, bank 0 drained first");

        // ---- scenario 4: drain bank 1 with rd_ready toggling
        clr();
        mism = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b0, (i % 2 == 0), 1'b0);
            if (s_rd_en !== (i % 2 == 0)) mism++;
        end
        chk("s4 rd_en follows rd_ready", mism, 0);
        chk("s4 reads", n_rd, FRAME);
        chk("s4 out_last count", n_outlast, 1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("s4 idle rd_en", 32'(s_rd_en), 0);
        chk("s4 err_ovf sticky", 32'(s_err_ovf), 1);
        sb_check("s4");
        $display("scenario 4: gapped drain, reads=%0d", n_rd);

        // ---- scenario 5: reset in mid-frame
        clr();
        for (int i = 0; i < FRAME + 500; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 500; i++) step(1'b1, 1'b1, 1'b0);
        chk("s5 writes before reset", n_wr, FRAME + 1000);
        chk("s5 reads before reset", n_rd, 500);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        chk("s5 post-reset wr_ready", 32'(s_wr_ready), 1);
        chk("s5 post-reset wr_addr", 32'(s_wr_addr), 0);
        chk("s5 post-reset wr_bank", 32'(s_wr_bank), 0);
        chk("s5 post-reset rd_en", 32'(s_rd_en), 0);
        chk("s5 post-reset rd_bank", 32'(s_rd_bank), 0);
        chk("s5 post-reset out_valid", 32'(s_out_valid), 0);
        chk("s5 post-reset err_ovf", 32'(s_err_ovf), 0);
        step(1'b1, 1'b1, 1'b0);
        chk("s5 restart wr_en", 32'(s_wr_en), 1);
        chk("s5 restart wr_addr", 32'(s_wr_addr), 0);
        chk("s5 restart rd_en", 32'(s_rd_en), 0);
        sb_check("s5");
        $display("scenario 5: mid-frame reset discarded partial frames");

`ifdef REORDER_SCHED_BYPASS_EN
        // ---- scenario 6: bypass latched per frame
        step(1'b0, 1'b0, 1'b1);
        clr();
        cfg_bypass = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (i == 100) cfg_bypass = 1'b0;
            if (i == FRAME + 100) cfg_bypass = 1'b1;
            step(1'b1, 1'b1, 1'b0);
        end
        for (int i = 0; i < FRAME + 3; i++) step(1'b0, 1'b1, 1'b0);
        chk("s6 reads", n_rd, 2 * FRAME);
        chk("s6 bypass rd_addr[1]", 32'(rd_log[1]), 1);
        chk("s6 bypass rd_addr[2]", 32'(rd_log[2]), 2);
        chk("s6 bypass rd_addr[0x123]", 32'(rd_log['h123]), 'h123);
        chk("s6 reversed rd_addr[1]", 32'(rd_log[FRAME + 1]), 'h100);
        chk("s6 reversed rd_addr[2]", 32'(rd_log[FRAME + 2]), 'h200);
        sb_check("s6");
        $display("scenario 6: bypass frame then reversed frame");
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/reorder_pingpong_sched.md
Name: reorder_pingpong_sched

Overview:
- Scheduler for the two-bank output re-order memory behind the radix-16 FFT core.
- Generates natural-order write addresses for frames arriving from the FFT, and digit-reversed read addresses to drain completed frames to downstream.
- Alternates the banks ping-pong style, so one frame can fill while the previous one drains.
- Applies backpressure to both sides and flags dropped writes.

Parameters:
- ADDR_WIDTH, 12, address bits per bank; frame length = 2^ADDR_WIDTH. Must be a multiple of DIGIT_WIDTH.
- DIGIT_WIDTH, 4, radix digit width (4 = radix-16) used for read-address digit reversal.
- RD_LAT, 1, memory read latency in cycles; sets the out_valid/out_last delay.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- wr_valid  input  1  FFT output sample valid.
- wr_ready  output  1  write bank available.
- wr_en  output  1  memory write strobe (= wr_valid & wr_ready).
- wr_bank  output  1  bank being written.
- wr_addr  output  ADDR_WIDTH  natural-order write address.
- rd_ready  input  1  downstream can accept a sample.
- rd_en  output  1  memory read strobe.
- rd_bank  output  1  bank being read.
- rd_addr  output  ADDR_WIDTH  digit-reversed read address.
- out_valid  output  1  rd_en delayed RD_LAT cycles.
- out_last  output  1  marks the final sample of a frame, aligned with out_valid.
- err_ovf  output  1  sticky flag: wr_valid seen while wr_ready=0.

Behaviour:
- Reset, synchronous, active-high, takes effect at any time including mid-frame:
  - Both bank states EMPTY; wr_sel=0, rd_sel=0; both counters 0; err_ovf=0; RD_LAT pipeline cleared.
  - All outputs 0 except wr_ready=1.
  - Partially written or read frames are discarded.
- Per-bank state, 2 bits, registered:
  - EMPTY -> FILLING: on the first wr_en to that bank.
  - FILLING -> FULL: on the wr_en with wr_cnt = 2^ADDR_WIDTH-1.
  - FULL -> DRAINING: on the first rd_en.
  - DRAINING -> EMPTY: on the rd_en with rd_cnt = 2^ADDR_WIDTH-1.
- Write side:
  - wr_ready = state[wr_sel] is EMPTY or FILLING, decoded from registered state only (no combinational path from rd_*).
  - wr_addr = wr_cnt and wr_bank = wr_sel, both combinational from registers.
  - On wr_en: wr_cnt increments and wraps to 0 at the frame end; wr_sel toggles on the last write.
- Read side:
  - rd_en = rd_ready & (state[rd_sel] is FULL or DRAINING).
  - rd_bank = rd_sel.
  - rd_addr = rd_cnt with its DIGIT_WIDTH-bit digit groups in reversed order (least-significant digit becomes most-significant).
  - On rd_en: rd_cnt increments and wraps to 0; rd_sel toggles on the last read.
- Latency:
  - Last write of a frame at cycle T -> earliest first rd_en at T+1.
  - Last read at cycle T -> bank writable (wr_ready=1) at T+1.
  - Same-cycle events on different banks are independent.
  - Same-cycle completion on the same bank cannot occur by construction.
- Both banks FULL/DRAINING -> wr_ready=0. If wr_valid=1 in that cycle: no wr_en, err_ovf set, and it stays 1 until reset.
- rd_ready low mid-frame: rd_cnt holds and drain resumes where it stopped. There is no timeout.
- out_valid/out_last are rd_en and (rd_en & rd_cnt==max) delayed exactly RD_LAT cycles; bubbles are preserved.

Optional Feature:
- Macro REORDER_SCHED_BYPASS_EN.
- When defined:
  - Adds input port cfg_bypass (1 bit).
  - cfg_bypass is sampled on each bank's EMPTY->FILLING transition and stored per bank.
  - While draining a bank whose stored bypass=1, rd_addr = rd_cnt (natural order).
  - Changing cfg_bypass mid-frame has no effect on frames already started.
- When undefined: no port, no per-bank flag, rd_addr always digit-reversed.

Test Plan:
- Reset, then 4096 consecutive wr_valid with rd_ready=1 -> wr_addr 0..4095 on bank 0, then rd_en from the next cycle with rd_addr sequence 0x000, 0x100, 0x200, …, 0xF00, 0x010, …; rd_cnt=0x123 -> rd_addr 0x321. out_valid trails rd_en by 1 cycle; out_last is high only with the 4096th out_valid.
- Continuous wr_valid with rd_ready=1 for 3 frames -> wr_ready never drops; wr_bank 0,1,0; rd_bank 0,1 lagging one frame; err_ovf=0.
- rd_ready=0 while 2 frames are written, wr_valid held high -> wr_ready=0 from the cycle after the 8192nd write; err_ovf=1 from the next cycle; raising rd_ready drains bank 0 first.
- rd_ready toggled 1/0 every cycle during drain -> rd_addr sequence unchanged, with gaps; out_valid pattern equals rd_en delayed 1 cycle.
- rst pulsed for 1 cycle after 1000 writes and 500 reads of the next frame -> next cycle all states EMPTY, wr_addr=0, wr_bank=0, rd_en=0, err_ovf=0.
- With REORDER_SCHED_BYPASS_EN: frame 0 with cfg_bypass=1, frame 1 with cfg_bypass=0 -> bank 0 reads 0,1,2,…; bank 1 reads 0x000, 0x100, …
